// File: rtl/hdlc_pkg.sv
// Shared definitions for the HDLC transmit-frame scheduler: FSM encoding,
// error-bit positions and descriptor length limits.
package hdlc_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LAUNCH    = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_GAP       = 2'd3;

    localparam int ERR_TIMEOUT  = 0;
    localparam int ERR_BAD_LEN  = 1;
    localparam int ERR_OVERFLOW = 2;

    localparam int unsigned HDLC_MAX_LEN = 512;
    localparam int          LEN_W        = 10;
    localparam int          BUF_W        = 2;
    localparam int          DESC_W       = BUF_W + LEN_W;

    function automatic logic len_ok(input logic [LEN_W-1:0] len, input int unsigned max_len);
        return (len != '0) && ({22'd0, len} <= max_len);
    endfunction

endpackage

// File: rtl/hdlc_desc_fifo.sv
// Synchronous descriptor FIFO with occupancy count, flush and same-cycle push/pop.
module hdlc_desc_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 12
) (
    input  logic                       clk_100m,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // Flush wins over everything; the head already read by a pop is kept by the caller.
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_100m) begin
        if (push && !flush) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/hdlc_tx_sched.sv
// Transmit-frame scheduler: queues DSP descriptors, launches one frame at a time
// towards the HDLC transmitter, waits for end-of-frame and enforces the inter-frame gap.
module hdlc_tx_sched
    import hdlc_pkg::*;
#(
    parameter int          DEPTH       = 4,
    parameter int unsigned MAX_LEN     = HDLC_MAX_LEN,
    parameter int unsigned START_HOLD  = 100,
    parameter int unsigned GAP_CYC     = 1000,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic                    clk_100m,
    input  logic                    rst_n,
    input  logic                    sched_en,
    input  logic                    desc_wr,
    input  logic [1:0]              desc_buf,
    input  logic [9:0]              desc_len,
    input  logic                    flush,
    input  logic                    clr_err,
    input  logic                    inr_tx,
    output logic                    trastart_flag,
    output logic [9:0]              db,
    output logic [1:0]              tx_buf,
    output logic                    tx_busy,
    output logic [$clog2(DEPTH):0]  q_count,
    output logic                    q_full,
    output logic                    done_pulse,
    output logic [2:0]              err_sticky,
    output logic [15:0]             frame_cnt
);

    logic              inr_tx_p0;
    logic              inr_tx_p1;
    logic              inr_tx_p2;
    logic              eof_evt;
    logic [1:0]        state;
    logic [31:0]       cnt;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              len_good;
    logic              tmo_evt;
    logic [2:0]        err_evt;
    logic [DESC_W-1:0] head;

    // Stage p0/p1: metastability filter for the clk_2m end-of-frame strobe; p2: edge history
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            inr_tx_p0 <= 1'b0;
            inr_tx_p1 <= 1'b0;
            inr_tx_p2 <= 1'b0;
        end else begin
            inr_tx_p0 <= inr_tx;
            inr_tx_p1 <= inr_tx_p0;
            inr_tx_p2 <= inr_tx_p1;
        end
    end

    assign eof_evt = inr_tx_p1 & ~inr_tx_p2;

    assign len_good = len_ok(desc_len, MAX_LEN);
    assign pop      = (state == ST_IDLE) && sched_en && !fifo_empty;
    // A full queue still accepts when the head leaves in the same cycle.
    assign push     = desc_wr && !flush && len_good && (!q_full || pop);
    assign tmo_evt  = (state == ST_WAIT_DONE) && !eof_evt && (cnt == TIMEOUT_CYC - 1);

    always_comb begin
        err_evt               = '0;
        err_evt[ERR_TIMEOUT]  = tmo_evt;
        err_evt[ERR_BAD_LEN]  = desc_wr && !flush && !len_good;
        err_evt[ERR_OVERFLOW] = desc_wr && !flush && len_good && q_full && !pop;
    end

    hdlc_desc_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DESC_W)
    ) u_fifo (
        .clk_100m (clk_100m),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .wr_data  ({desc_buf, desc_len}),
        .rd_data  (head),
        .count    (q_count),
        .full     (q_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            trastart_flag <= 1'b0;
            done_pulse    <= 1'b0;
            frame_cnt     <= '0;
            db            <= '0;
            tx_buf        <= '0;
        end else begin
            done_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        db            <= head[LEN_W-1:0];
                        tx_buf        <= head[DESC_W-1:LEN_W];
                        trastart_flag <= 1'b1;
                        cnt           <= '0;
                        state         <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    if (cnt == START_HOLD - 1) begin
                        trastart_flag <= 1'b0;
                        cnt           <= '0;
                        state         <= ST_WAIT_DONE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (eof_evt) begin
                        done_pulse <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                        cnt        <= '0;
                        state      <= ST_GAP;
                    end else if (tmo_evt) begin
                        cnt   <= '0;
                        state <= ST_GAP;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_CYC - 1) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // An error raised in the same cycle as clr_err survives the clear.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= '0;
        end else begin
            err_sticky <= (clr_err ? 3'b000 : err_sticky) | err_evt;
        end
    end

    assign tx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_hdlc_tx_sched.sv
// Self-checking bench for hdlc_tx_sched: directed table/sequences plus a randomized
// run checked against a queue-level reference model.
module tb_hdlc_tx_sched;

    localparam int DEPTH = 4;
    localparam int SH    = 100;
    localparam int GAP   = 1000;
    localparam int TMO   = 3000;
    localparam int MAXL  = 512;

    logic        clk_100m = 1'b0;
    logic        rst_n, sched_en, desc_wr, flush, clr_err, inr_tx;
    logic [1:0]  desc_buf;
    logic [9:0]  desc_len;
    logic        trastart_flag, tx_busy, q_full, done_pulse;
    logic [9:0]  db;
    logic [1:0]  tx_buf;
    logic [2:0]  q_count;
    logic [2:0]  err_sticky;
    logic [15:0] frame_cnt;

    always #5 clk_100m = ~clk_100m;

    hdlc_tx_sched #(
        .DEPTH(DEPTH), .MAX_LEN(MAXL), .START_HOLD(SH), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk_100m(clk_100m), .rst_n(rst_n), .sched_en(sched_en), .desc_wr(desc_wr),
        .desc_buf(desc_buf), .desc_len(desc_len), .flush(flush), .clr_err(clr_err),
        .inr_tx(inr_tx), .trastart_flag(trastart_flag), .db(db), .tx_buf(tx_buf),
        .tx_busy(tx_busy), .q_count(q_count), .q_full(q_full), .done_pulse(done_pulse),
        .err_sticky(err_sticky), .frame_cnt(frame_cnt)
    );

    int  n_chk = 0, n_fail = 0, cyc = 0;
    int  hold_len = 0, last_end = 0, rises = 0, dones = 0;
    bit  prev_ts, prev_done, prev_err0, end_valid, rose_now;
    bit  auto_resp = 1'b0, resp_rand = 1'b0;
    int  resp_dly = 30;
    logic [11:0] launch_log[$];

    typedef struct {
        logic [1:0] b;
        logic [9:0] len;
        bit         clr;
        int         exp_q;
        bit         exp_full;
        logic [2:0] exp_err;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock: sample just after the edge and track launch/hold/gap/done timing.
    task automatic tick();
        @(posedge clk_100m);
        #1;
        cyc++;
        rose_now = 1'b0;
        if (!rst_n) begin
            prev_ts = 0; prev_done = 0; prev_err0 = 0; end_valid = 0; hold_len = 0;
        end else begin
            if (trastart_flag) begin
                if (!prev_ts) begin
                    rose_now = 1'b1;
                    rises++;
                    launch_log.push_back({tx_buf, db});
                    if (end_valid) chk("gap_before_launch", (cyc - last_end) >= GAP + 1, 1);
                end
                hold_len++;
            end else if (prev_ts) begin
                chk("start_hold", hold_len, SH);
                hold_len = 0;
            end
            if (done_pulse) begin
                dones++;
                chk("done_width", prev_done, 0);
            end
            if (done_pulse || (err_sticky[0] && !prev_err0)) begin
                last_end  = cyc;
                end_valid = 1'b1;
            end
            prev_ts = trastart_flag; prev_done = done_pulse; prev_err0 = err_sticky[0];
        end
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0:       return trastart_flag;
            1:       return !trastart_flag;
            2:       return done_pulse;
            default: return !tx_busy && (q_count == 3'd0);
        endcase
    endfunction

    task automatic wait_for(input int sel, input int lim, input string nm);
        int n = 0;
        while (!cond(sel) && n < lim) begin
            tick();
            n++;
        end
        chk(nm, cond(sel), 1);
    endtask

    task automatic enq(input logic [1:0] b, input logic [9:0] l);
        desc_buf = b; desc_len = l; desc_wr = 1'b1;
        tick();
        desc_wr = 1'b0;
    endtask

    // Transmitter stand-in: answers each start request with one clk_2m-wide end-of-frame.
    initial begin
        inr_tx = 1'b0;
        forever begin
            @(negedge trastart_flag);
            if (auto_resp && rst_n) begin
                int d;
                d = resp_rand ? int'($urandom_range(5, 120)) : resp_dly;
                repeat (d) @(posedge clk_100m);
                #1 inr_tx = 1'b1;
                repeat (50) @(posedge clk_100m);
                #1 inr_tx = 1'b0;
            end
        end
    end

    initial begin
        logic [11:0] mq[$];
        logic [2:0]  merr;
        int          d0, base_rises, base_dones, dones_at_rst;

        rst_n = 1'b0; sched_en = 0; desc_wr = 0; flush = 0; clr_err = 0;
        desc_buf = '0; desc_len = '0;
        repeat (3) tick();
        chk("rst_trastart", trastart_flag, 0);
        chk("rst_db", db, 0);
        chk("rst_tx_buf", tx_buf, 0);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_q_count", q_count, 0);
        chk("rst_q_full", q_full, 0);
        chk("rst_done", done_pulse, 0);
        chk("rst_err", err_sticky, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Basic launch
        sched_en = 1; auto_resp = 1; resp_dly = 2000;
        enq(2'd1, 10'd64);
        chk("basic_q_after_wr", q_count, 1);
        tick();
        chk("basic_trastart", trastart_flag, 1);
        chk("basic_db", db, 64);
        chk("basic_tx_buf", tx_buf, 1);
        chk("basic_busy", tx_busy, 1);
        chk("basic_q_after_pop", q_count, 0);
        wait_for(1, SH + 5, "basic_launch_end");
        wait_for(2, 3000, "basic_done");
        chk("basic_frame_cnt", frame_cnt, 1);
        repeat (GAP - 1) tick();
        chk("basic_busy_in_gap", tx_busy, 1);
        tick();
        chk("basic_busy_after_gap", tx_busy, 0);

        // Back-to-back launches in order
        resp_dly = 30;
        launch_log.delete();
        enq(2'd0, 10'd10); enq(2'd1, 10'd20); enq(2'd2, 10'd30);
        wait_for(3, 6000, "b2b_drain");
        chk("b2b_frame_cnt", frame_cnt, 4);
        chk("b2b_launches", launch_log.size(), 3);
        if (launch_log.size() == 3) begin
            chk("b2b_desc0", launch_log[0], {2'd0, 10'd10});
            chk("b2b_desc1", launch_log[1], {2'd1, 10'd20});
            chk("b2b_desc2", launch_log[2], {2'd2, 10'd30});
        end

        // Length and overflow table, scheduler held off
        sched_en = 0;
        tbl[0] = '{2'd0, 10'd0,    1'b0, 0, 1'b0, 3'b010};
        tbl[1] = '{2'd1, 10'd513,  1'b0, 0, 1'b0, 3'b010};
        tbl[2] = '{2'd2, 10'd512,  1'b0, 1, 1'b0, 3'b010};
        tbl[3] = '{2'd3, 10'd1023, 1'b0, 1, 1'b0, 3'b010};
        tbl[4] = '{2'd1, 10'd1,    1'b1, 2, 1'b0, 3'b000};
        tbl[5] = '{2'd2, 10'd0,    1'b1, 2, 1'b0, 3'b010};
        tbl[6] = '{2'd3, 10'd5,    1'b0, 3, 1'b0, 3'b010};
        tbl[7] = '{2'd0, 10'd6,    1'b0, 4, 1'b1, 3'b010};
        tbl[8] = '{2'd1, 10'd7,    1'b0, 4, 1'b1, 3'b110};
        for (int i = 0; i < 9; i++) begin
            desc_buf = tbl[i].b; desc_len = tbl[i].len; clr_err = tbl[i].clr; desc_wr = 1'b1;
            tick();
            desc_wr = 1'b0; clr_err = 1'b0;
            chk($sformatf("tbl%0d_q_count", i), q_count, tbl[i].exp_q);
            chk($sformatf("tbl%0d_q_full", i), q_full, tbl[i].exp_full);
            chk($sformatf("tbl%0d_err", i), err_sticky, tbl[i].exp_err);
        end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("clr_err", err_sticky, 0);
        chk("clr_keeps_queue", q_count, 4);

        // Full queue: write on the pop cycle is accepted
        launch_log.delete();
        resp_dly = 200;
        sched_en = 1; desc_buf = 2'd2; desc_len = 10'd100; desc_wr = 1'b1;
        tick();
        desc_wr = 1'b0;
        chk("simul_q_count", q_count, 4);
        chk("simul_q_full", q_full, 1);
        chk("simul_err", err_sticky, 0);
        chk("simul_trastart", trastart_flag, 1);
        chk("simul_db", db, 512);
        chk("simul_tx_buf", tx_buf, 2);

        // Flush during WAIT_DONE; same-cycle write dropped silently
        wait_for(1, SH + 5, "flush_launch_end");
        flush = 1'b1; desc_wr = 1'b1; desc_len = 10'd50;
        tick();
        flush = 1'b0; desc_wr = 1'b0;
        chk("flush_q_count", q_count, 0);
        chk("flush_q_full", q_full, 0);
        chk("flush_err", err_sticky, 0);
        chk("flush_busy", tx_busy, 1);
        wait_for(2, 1000, "flush_frame_done");
        chk("flush_frame_cnt", frame_cnt, 5);
        wait_for(3, GAP + 10, "flush_idle");
        chk("flush_no_relaunch", launch_log.size(), 1);

        // Timeout with no end-of-frame
        auto_resp = 0;
        d0 = dones;
        enq(2'd3, 10'd77);
        wait_for(0, 5, "tmo_launch");
        wait_for(1, SH + 5, "tmo_launch_end");
        repeat (TMO - 1) tick();
        chk("tmo_err_early", err_sticky, 0);
        chk("tmo_busy", tx_busy, 1);
        tick();
        chk("tmo_err_set", err_sticky, 3'b001);
        chk("tmo_no_done", dones - d0, 0);
        chk("tmo_frame_cnt", frame_cnt, 5);
        auto_resp = 1; resp_dly = 30;
        enq(2'd0, 10'd99);
        wait_for(0, GAP + 10, "post_tmo_launch");
        chk("post_tmo_db", db, 99);
        wait_for(2, 1000, "post_tmo_done");
        chk("post_tmo_frame_cnt", frame_cnt, 6);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("post_tmo_clr", err_sticky, 0);
        wait_for(3, GAP + 10, "post_tmo_idle");

        // Reset in the middle of LAUNCH
        auto_resp = 0;
        enq(2'd1, 10'd200);
        wait_for(0, 5, "rst_mid_launch");
        enq(2'd2, 10'd300);
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_trastart", trastart_flag, 0);
        chk("midrst_busy", tx_busy, 0);
        chk("midrst_db", db, 0);
        chk("midrst_tx_buf", tx_buf, 0);
        chk("midrst_frame_cnt", frame_cnt, 0);
        chk("midrst_q_count", q_count, 0);
        chk("midrst_err", err_sticky, 0);
        tick();
        rst_n = 1'b1;
        tick();
        dones_at_rst = dones;

        // Randomized traffic against the queue-level model
        sched_en = 0;
        auto_resp = 1; resp_rand = 1;
        merr = '0;
        base_rises = rises; base_dones = dones;
        for (int i = 0; i < 9000; i++) begin
            bit w, f, c;
            logic [9:0] l;
            logic [1:0] b;
            sched_en = ($urandom_range(0, 19) != 0);
            w = ($urandom_range(0, 99) == 0);
            f = ($urandom_range(0, 1999) == 0);
            c = ($urandom_range(0, 399) == 0);
            case ($urandom_range(0, 9))
                0:       l = 10'd0;
                1:       l = 10'($urandom_range(513, 1023));
                2:       l = 10'd512;
                default: l = 10'($urandom_range(1, 512));
            endcase
            b = 2'($urandom_range(0, 3));
            desc_wr = w; flush = f; clr_err = c; desc_len = l; desc_buf = b;
            tick();
            if (rose_now) begin
                if (mq.size() == 0) chk("rnd_pop_from_empty", 1, 0);
                else chk("rnd_launch_desc", {tx_buf, db}, mq.pop_front());
            end
            if (c) merr = '0;
            if (w && !f) begin
                if (l == 0 || int'(l) > MAXL) merr[1] = 1'b1;
                else if (mq.size() >= DEPTH)  merr[2] = 1'b1;
                else                          mq.push_back({b, l});
            end
            if (f) mq.delete();
            chk("rnd_q_count", q_count, mq.size());
            chk("rnd_q_full", q_full, mq.size() == DEPTH);
            chk("rnd_err", err_sticky, merr);
        end
        desc_wr = 0; flush = 0; clr_err = 0; sched_en = 1;
        begin
            int n = 0;
            while (!(!tx_busy && q_count == 3'd0) && n < 8000) begin
                tick();
                if (rose_now) begin
                    if (mq.size() == 0) chk("drain_pop_from_empty", 1, 0);
                    else chk("drain_launch_desc", {tx_buf, db}, mq.pop_front());
                end
                n++;
            end
        end
        chk("rnd_drained", !tx_busy && q_count == 3'd0, 1);
        chk("rnd_model_empty", mq.size(), 0);
        chk("rnd_done_vs_launch", dones - base_dones, rises - base_rises);
        chk("rnd_frame_cnt", frame_cnt, 16'(dones - dones_at_rst));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
